// File: rtl/aibcr3_dcc_pkg.sv
// Shared types and default constants for the DCC delay-line controller.
package aibcr3_dcc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EVAL   = 2'd2
    } dcc_state_t;

    localparam int DEF_NCELL     = 16;
    localparam int DEF_CODE_W    = 5;
    localparam int DEF_INIT_CODE = 8;
    localparam int DEF_SETTLE    = 8;
    localparam int DEF_FILT_TH   = 4;
    localparam int DEF_LOCK_REV  = 4;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aibcr3_dcc_updn_filt.sv
// Up/down majority filter: signed accumulator that emits a one-cycle step
// pulse on the cycle whose update would reach +/-FILT_TH.
module aibcr3_dcc_updn_filt #(
    parameter int FILT_TH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic up,
    input  logic dn,
    output logic step_up,
    output logic step_dn
);

    localparam int ACC_W = $clog2(FILT_TH + 1) + 1;
    localparam logic signed [ACC_W-1:0] TH_P1 = ACC_W'(FILT_TH - 1);
    localparam logic signed [ACC_W-1:0] TH_M1 = ACC_W'(1 - FILT_TH);

    logic signed [ACC_W-1:0] acc;
    logic                    inc;
    logic                    dec;

    assign inc = en & up & ~dn;
    assign dec = en & dn & ~up;

    // Pulse is combinational so the code register moves on the same edge.
    assign step_up = inc && (acc == TH_P1);
    assign step_dn = dec && (acc == TH_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr || step_up || step_dn) begin
            acc <= '0;
        end else if (inc) begin
            acc <= acc + ACC_W'(1);
        end else if (dec) begin
            acc <= acc - ACC_W'(1);
        end
    end

endmodule

// File: rtl/aibcr3_dcc_dly_ctrl.sv
// DCC delay-line controller: filters detector decisions, steps a thermometer
// select one cell at a time, and reports lock and saturation.
//
//   state  | meaning
//   IDLE   | loop disabled or overridden; code held or forced
//   SETTLE | waiting for the delay line to settle after a code change
//   EVAL   | accumulating up/dn decisions until a step is taken
module aibcr3_dcc_dly_ctrl
    import aibcr3_dcc_pkg::*;
#(
    parameter int NCELL     = DEF_NCELL,
    parameter int CODE_W    = DEF_CODE_W,
    parameter int INIT_CODE = DEF_INIT_CODE,
    parameter int SETTLE    = DEF_SETTLE,
    parameter int FILT_TH   = DEF_FILT_TH,
    parameter int LOCK_REV  = DEF_LOCK_REV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dcc_en,
    input  logic              up,
    input  logic              dn,
    input  logic              ovrd_en,
    input  logic [CODE_W-1:0] ovrd_code,
    output logic [NCELL-1:0]  bk,
    output logic [CODE_W-1:0] code,
    output logic              lock,
    output logic              sat_hi,
    output logic              sat_lo
);

    localparam int CNT_W  = cnt_width(SETTLE);
    localparam int HIST_W = cnt_width(LOCK_REV + 1);
    localparam logic [CODE_W-1:0] CODE_MAX  = CODE_W'(NCELL);
    localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(INIT_CODE);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE - 1);
    localparam logic [HIST_W-1:0] HIST_MAX  = HIST_W'(LOCK_REV);

    dcc_state_t        state, state_nxt;
    logic [CNT_W-1:0]  settle_cnt, settle_cnt_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic [CODE_W-1:0] code_clamp;
    logic [NCELL-1:0]  bk_nxt;
    logic [NCELL-1:0]  bk_init;
    logic              lock_nxt, sat_hi_nxt, sat_lo_nxt;
    logic [HIST_W-1:0] rev_cnt, rev_cnt_nxt;
    logic [HIST_W-1:0] same_cnt, same_cnt_nxt;
    logic              last_up, last_up_nxt;
    logic              have_prev, have_prev_nxt;
    logic              filt_en;
    logic              step_up, step_dn;

    assign filt_en    = (state == ST_EVAL) && dcc_en && !ovrd_en;
    assign code_clamp = (ovrd_code > CODE_MAX) ? CODE_MAX : ovrd_code;

    aibcr3_dcc_updn_filt #(
        .FILT_TH (FILT_TH)
    ) u_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (filt_en),
        .clr     (!filt_en),
        .up      (up),
        .dn      (dn),
        .step_up (step_up),
        .step_dn (step_dn)
    );

    for (genvar g = 0; g < NCELL; g++) begin : g_therm
        assign bk_nxt[g]  = (code_nxt > CODE_W'(g));
        assign bk_init[g] = (g < INIT_CODE);
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        code_nxt       = code;
        lock_nxt       = lock;
        sat_hi_nxt     = sat_hi;
        sat_lo_nxt     = sat_lo;
        rev_cnt_nxt    = rev_cnt;
        same_cnt_nxt   = same_cnt;
        last_up_nxt    = last_up;
        have_prev_nxt  = have_prev;

        if (ovrd_en || !dcc_en) begin
            state_nxt      = ST_IDLE;
            settle_cnt_nxt = '0;
            if (ovrd_en) begin
                code_nxt = code_clamp;
            end
            lock_nxt      = 1'b0;
            sat_hi_nxt    = 1'b0;
            sat_lo_nxt    = 1'b0;
            rev_cnt_nxt   = '0;
            same_cnt_nxt  = '0;
            last_up_nxt   = 1'b0;
            have_prev_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt      = ST_SETTLE;
                    settle_cnt_nxt = CNT_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state_nxt = ST_EVAL;
                    end else begin
                        settle_cnt_nxt = settle_cnt - CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    if (step_up || step_dn) begin
                        state_nxt      = ST_SETTLE;
                        settle_cnt_nxt = CNT_LOAD;
                        if (step_up) begin
                            if (code == CODE_MAX) begin
                                sat_hi_nxt = 1'b1;
                            end else begin
                                code_nxt   = code + CODE_W'(1);
                                sat_lo_nxt = 1'b0;
                            end
                        end else begin
                            if (code == '0) begin
                                sat_lo_nxt = 1'b1;
                            end else begin
                                code_nxt   = code - CODE_W'(1);
                                sat_hi_nxt = 1'b0;
                            end
                        end
                        // Saturated attempts still count toward the step history.
                        if (have_prev && (step_up != last_up)) begin
                            rev_cnt_nxt  = (rev_cnt == HIST_MAX) ? HIST_MAX : rev_cnt + HIST_W'(1);
                            same_cnt_nxt = '0;
                            if (rev_cnt_nxt == HIST_MAX) begin
                                lock_nxt = 1'b1;
                            end
                        end else if (have_prev) begin
                            same_cnt_nxt = (same_cnt == HIST_MAX) ? HIST_MAX : same_cnt + HIST_W'(1);
                            rev_cnt_nxt  = '0;
                            if (same_cnt_nxt == HIST_MAX) begin
                                lock_nxt = 1'b0;
                            end
                        end
                        have_prev_nxt = 1'b1;
                        last_up_nxt   = step_up;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            code       <= CODE_INIT;
            bk         <= bk_init;
            lock       <= 1'b0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
            rev_cnt    <= '0;
            same_cnt   <= '0;
            last_up    <= 1'b0;
            have_prev  <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            code       <= code_nxt;
            bk         <= bk_nxt;
            lock       <= lock_nxt;
            sat_hi     <= sat_hi_nxt;
            sat_lo     <= sat_lo_nxt;
            rev_cnt    <= rev_cnt_nxt;
            same_cnt   <= same_cnt_nxt;
            last_up    <= last_up_nxt;
            have_prev  <= have_prev_nxt;
        end
    end

endmodule

// File: tb/tb_aibcr3_dcc_dly_ctrl.sv
// Directed bench for the DCC delay-line controller with default parameters.
module tb_aibcr3_dcc_dly_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dcc_en = 1'b0;
    logic        up = 1'b0;
    logic        dn = 1'b0;
    logic        ovrd_en = 1'b0;
    logic [4:0]  ovrd_code = '0;
    logic [15:0] bk;
    logic [4:0]  code;
    logic        lock;
    logic        sat_hi;
    logic        sat_lo;

    int errors = 0;
    int checks = 0;

    aibcr3_dcc_dly_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dcc_en    (dcc_en),
        .up        (up),
        .dn        (dn),
        .ovrd_en   (ovrd_en),
        .ovrd_code (ovrd_code),
        .bk        (bk),
        .code      (code),
        .lock      (lock),
        .sat_hi    (sat_hi),
        .sat_lo    (sat_lo)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and land on the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; dcc_en = 1'b0; up = 1'b0; dn = 1'b0;
        ovrd_en = 1'b0; ovrd_code = '0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (code !== 5'd8) begin errors++; $display("FAIL reset_code: got %0d want 8", code); end
        checks++; if (bk !== 16'h00FF) begin errors++; $display("FAIL reset_bk: got %h want 00ff", bk); end
        checks++; if ({lock, sat_hi, sat_lo} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {lock, sat_hi, sat_lo}); end
        tick(5);
        checks++; if (code !== 5'd8) begin errors++; $display("FAIL idle_hold: got %0d want 8", code); end
    endtask

    task automatic test_up_steps();
        do_reset();
        dcc_en = 1'b1; up = 1'b1;
        tick(12);
        checks++; if (code !== 5'd8) begin errors++; $display("FAIL first_step_early: got %0d want 8", code); end
        tick(1);
        checks++; if (code !== 5'd9) begin errors++; $display("FAIL first_step_code: got %0d want 9", code); end
        checks++; if (bk !== 16'h01FF) begin errors++; $display("FAIL first_step_bk: got %h want 01ff", bk); end
        tick(11);
        checks++; if (code !== 5'd9) begin errors++; $display("FAIL step_period_early: got %0d want 9", code); end
        tick(1);
        checks++; if (code !== 5'd10) begin errors++; $display("FAIL second_step_code: got %0d want 10", code); end
        checks++; if (bk !== 16'h03FF) begin errors++; $display("FAIL second_step_bk: got %h want 03ff", bk); end
    endtask

    // Continues from code 10 left by test_up_steps.
    task automatic test_sat_hi();
        for (int k = 11; k <= 16; k++) begin
            tick(12);
            checks++; if (code !== 5'(k) || sat_hi !== 1'b0) begin errors++; $display("FAIL ramp_up: got code=%0d sat_hi=%b want %0d/0", code, sat_hi, k); end
        end
        tick(12);
        checks++; if (code !== 5'd16) begin errors++; $display("FAIL sat_hi_code: got %0d want 16", code); end
        checks++; if (bk !== 16'hFFFF) begin errors++; $display("FAIL sat_hi_bk: got %h want ffff", bk); end
        checks++; if (sat_hi !== 1'b1) begin errors++; $display("FAIL sat_hi_set: got %b want 1", sat_hi); end
        tick(12);
        checks++; if (code !== 5'd16 || sat_hi !== 1'b1) begin errors++; $display("FAIL sat_hi_sticky: got code=%0d sat_hi=%b want 16/1", code, sat_hi); end
        up = 1'b0; dn = 1'b1;
        tick(12);
        checks++; if (code !== 5'd15 || bk !== 16'h7FFF) begin errors++; $display("FAIL sat_hi_release: got code=%0d bk=%h want 15/7fff", code, bk); end
        checks++; if (sat_hi !== 1'b0) begin errors++; $display("FAIL sat_hi_clear: got %b want 0", sat_hi); end
    endtask

    task automatic test_lock();
        logic exp_dir  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int   exp_code [9] = '{9, 8, 9, 8, 9, 10, 11, 12, 13};
        logic exp_lock [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        dcc_en = 1'b1;
        for (int s = 0; s < 9; s++) begin
            up = exp_dir[s]; dn = ~exp_dir[s];
            tick((s == 0) ? 13 : 12);
            checks++;
            if (code !== 5'(exp_code[s]) || lock !== exp_lock[s]) begin
                errors++;
                $display("FAIL lock_step%0d: got code=%0d lock=%b want %0d/%b", s, code, lock, exp_code[s], exp_lock[s]);
            end
        end
    endtask

    task automatic test_no_step();
        do_reset();
        dcc_en = 1'b1; up = 1'b1; dn = 1'b1;
        tick(60);
        checks++; if (code !== 5'd8) begin errors++; $display("FAIL both_high: got %0d want 8", code); end
        for (int i = 0; i < 60; i++) begin
            up = i[0]; dn = ~i[0];
            tick(1);
        end
        checks++; if (code !== 5'd8 || bk !== 16'h00FF) begin errors++; $display("FAIL alternating: got code=%0d bk=%h want 8/00ff", code, bk); end
    endtask

    task automatic test_ovrd();
        do_reset();
        dcc_en = 1'b1; ovrd_en = 1'b1; ovrd_code = 5'd20;
        tick(1);
        checks++; if (code !== 5'd16 || bk !== 16'hFFFF) begin errors++; $display("FAIL ovrd_clamp: got code=%0d bk=%h want 16/ffff", code, bk); end
        ovrd_code = 5'd0;
        tick(1);
        checks++; if (code !== 5'd0 || bk !== 16'h0000) begin errors++; $display("FAIL ovrd_jump: got code=%0d bk=%h want 0/0000", code, bk); end
        ovrd_en = 1'b0; dn = 1'b1;
        tick(12);
        checks++; if (code !== 5'd0 || sat_lo !== 1'b0) begin errors++; $display("FAIL ovrd_release_settle: got code=%0d sat_lo=%b want 0/0", code, sat_lo); end
        tick(1);
        checks++; if (code !== 5'd0 || sat_lo !== 1'b1) begin errors++; $display("FAIL sat_lo_set: got code=%0d sat_lo=%b want 0/1", code, sat_lo); end
        dn = 1'b0; up = 1'b1;
        tick(12);
        checks++; if (code !== 5'd1 || bk !== 16'h0001 || sat_lo !== 1'b0) begin errors++; $display("FAIL sat_lo_clear: got code=%0d bk=%h sat_lo=%b want 1/0001/0", code, bk, sat_lo); end
    endtask

    task automatic test_rst_mid_eval();
        do_reset();
        dcc_en = 1'b1; up = 1'b1;
        tick(49);
        checks++; if (code !== 5'd12) begin errors++; $display("FAIL reach_12: got %0d want 12", code); end
        tick(10);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (code !== 5'd8 || bk !== 16'h00FF) begin errors++; $display("FAIL async_rst_code: got code=%0d bk=%h want 8/00ff", code, bk); end
        checks++; if ({lock, sat_hi, sat_lo} !== 3'b000) begin errors++; $display("FAIL async_rst_flags: got %b want 000", {lock, sat_hi, sat_lo}); end
        @(negedge clk);
    endtask

    task automatic test_dis_mid_settle();
        do_reset();
        dcc_en = 1'b1; up = 1'b1;
        tick(13);
        checks++; if (code !== 5'd9) begin errors++; $display("FAIL dis_pre_step: got %0d want 9", code); end
        tick(3);
        dcc_en = 1'b0;
        tick(30);
        checks++; if (code !== 5'd9 || bk !== 16'h01FF) begin errors++; $display("FAIL dis_hold: got code=%0d bk=%h want 9/01ff", code, bk); end
        dcc_en = 1'b1;
        tick(12);
        checks++; if (code !== 5'd9) begin errors++; $display("FAIL reen_settle: got %0d want 9", code); end
        tick(1);
        checks++; if (code !== 5'd10) begin errors++; $display("FAIL reen_step: got %0d want 10", code); end
    endtask

    initial begin
        test_reset();
        test_up_steps();
        test_sat_hi();
        test_lock();
        test_no_step();
        test_ovrd();
        test_rst_mid_eval();
        test_dis_mid_settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
